// File: rtl/mdu_if.sv
// Start/done handshake and result bus between the execute stage and the mdu.
interface mdu_if #(parameter int WIDTH = 16);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             c;
  logic             z;
  logic             n;
  logic             dz;

  modport master (output start, op, a, b,
                  input  busy, done, hi, lo, c, z, n, dz);
  modport slave  (input  start, op, a, b,
                  output busy, done, hi, lo, c, z, n, dz);
endinterface

// File: rtl/mdu.sv
// Sequential 16-bit unsigned multiply (shift-add) / divide (restoring), one bit per clock.
// state | meaning: IDLE wait for start | CALC iterate 16 bits | DONE one-cycle result pulse
module mdu (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [15:0] opnd_q, opnd_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] hi_q, hi_d, lo_q, lo_d;
  logic        c_q, c_d, z_q, z_d, n_q, n_d, dz_q, dz_d;

  logic [16:0] add_sum;
  logic [16:0] rem_sh;
  logic [15:0] rem_sub;
  logic [31:0] step;

  // acc holds {upper, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    add_sum = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, opnd_q} : 17'd0);
    rem_sh  = {acc_q[31:16], acc_q[15]};
    rem_sub = rem_sh[15:0] - opnd_q;
    if (op_q) begin
      if (rem_sh >= {1'b0, opnd_q}) step = {rem_sub, acc_q[14:0], 1'b1};
      else                          step = {rem_sh[15:0], acc_q[14:0], 1'b0};
    end else begin
      step = {add_sum, acc_q[15:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op && (bus.b == 16'd0)) begin
            state_d = DONE;
            hi_d    = bus.a;
            lo_d    = 16'hFFFF;
            c_d     = 1'b0;
            z_d     = 1'b0;
            n_d     = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = 5'd0;
            op_d    = bus.op;
            acc_d   = bus.op ? {16'h0000, bus.a} : {16'h0000, bus.b};
            opnd_d  = bus.op ? bus.b : bus.a;
          end
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = DONE;
          hi_d    = step[31:16];
          lo_d    = step[15:0];
          dz_d    = 1'b0;
          if (op_q) begin
            c_d = 1'b0;
            z_d = (step[15:0] == 16'h0000);
            n_d = step[15];
          end else begin
            c_d = (step[31:16] != 16'h0000);
            z_d = (step == 32'h0000_0000);
            n_d = step[31];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 1'b0;
      opnd_q  <= 16'h0000;
      acc_q   <= 32'h0000_0000;
      hi_q    <= 16'h0000;
      lo_q    <= 16'h0000;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy = (state_q == CALC);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.c    = c_q;
  assign bus.z    = z_q;
  assign bus.n    = n_q;
  assign bus.dz   = dz_q;
endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed cases plus random operations against an arithmetic model.
module tb_mdu;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mdu_if bus ();
  mdu dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] ehi, output logic [15:0] elo,
                       output logic ec, output logic ez, output logic en, output logic edz);
    logic [31:0] p;
    if (!o) begin
      p   = 32'(x) * 32'(y);
      ehi = p[31:16];
      elo = p[15:0];
      ec  = (p >= 32'd65536);
      ez  = (p == 0);
      en  = (p >= 32'h8000_0000);
      edz = 1'b0;
    end else if (y == 0) begin
      ehi = x;
      elo = 16'hFFFF;
      ec  = 1'b0;
      ez  = 1'b0;
      en  = 1'b1;
      edz = 1'b1;
    end else begin
      ehi = x % y;
      elo = x / y;
      ec  = 1'b0;
      ez  = (elo == 0);
      en  = (elo >= 16'h8000);
      edz = 1'b0;
    end
  endtask

  task automatic chk_result(input logic o, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] ehi, elo;
    logic ec, ez, en, edz;
    model(o, x, y, ehi, elo, ec, ez, en, edz);
    chk("hi", bus.hi, ehi);
    chk("lo", bus.lo, elo);
    chk("c", bus.c, ec);
    chk("z", bus.z, ez);
    chk("n", bus.n, en);
    chk("dz", bus.dz, edz);
  endtask

  // called 1ns after a rising edge; returns 1ns after the edge that reopens IDLE
  task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y);
    int k;
    int nb;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    nb = 0;
    for (k = 1; k <= 40; k++) begin
      chk("busy_and_done", bus.busy & bus.done, 1'b0);
      if (bus.busy) nb++;
      if (bus.done) break;
      @(posedge clk); #1;
    end
    chk("latency", k, (o && y == 0) ? 1 : 17);
    chk("busy_cycles", nb, (o && y == 0) ? 0 : 16);
    chk_result(o, x, y);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
  endtask

  initial begin
    logic [15:0] x, y;
    logic        o;
    bit          any_done;
    bit          any_busy;
    total = 0;
    bad   = 0;

    // reset wins over a simultaneous start
    rst = 1'b1;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 16'd3;
    bus.b     = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_hilo", {bus.hi, bus.lo}, 32'h0);
    chk("rst_flags", {bus.c, bus.z, bus.n, bus.dz}, 4'h0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 16'd3, 16'd5);
    run_op(1'b0, 16'hFFFF, 16'hFFFF);
    run_op(1'b0, 16'h0000, 16'h1234);
    run_op(1'b1, 16'd100, 16'd7);
    run_op(1'b1, 16'd5, 16'd9);
    run_op(1'b1, 16'h1234, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("dz_hold_hi", bus.hi, 16'h1234);
    chk("dz_hold_dz", bus.dz, 1'b1);
    run_op(1'b1, 16'hFFFF, 16'h0001);

    // starts in CALC (+5) and DONE (+17) are ignored
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 16'd3;
    bus.b     = 16'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (k == 17) begin
        chk("ign_done", bus.done, 1'b1);
        chk_result(1'b0, 16'd3, 16'd5);
      end
      bus.start = (k == 5) || (k == 17);
      bus.op    = 1'b1;
      bus.a     = 16'd999;
      bus.b     = 16'd7;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("ign_not_busy", bus.busy, 1'b0);
    chk("ign_not_done", bus.done, 1'b0);
    run_op(1'b1, 16'd999, 16'd7);

    // reset mid-calculation aborts with no done pulse
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 16'd3;
    bus.b     = 16'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_hilo", {bus.hi, bus.lo}, 32'h0);
    chk("abort_flags", {bus.c, bus.z, bus.n, bus.dz}, 4'h0);
    any_done = 1'b0;
    any_busy = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      any_done |= bus.done;
      any_busy |= bus.busy;
    end
    chk("abort_no_done", any_done, 1'b0);
    chk("abort_no_busy", any_busy, 1'b0);
    run_op(1'b0, 16'd3, 16'd5);

    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 5) == 0) y = 16'($urandom_range(1, 3));
      run_op(o, x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Sequential 16-bit unsigned multiply/divide unit. It sits beside the single-cycle ALSU in the execute stage and handles the operations the ALSU cannot do in one cycle. It accepts one operation per start/done handshake and iterates one bit per clock (shift-add for multiply, restoring subtract for divide). Results and flags use the same conventions as the ALSU (c, z, n) so they can feed the same flag register.

## Interface
- WIDTH, 16, operand and result half-width; all behaviour below is specified for 16.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = MUL (unsigned), 1 = DIV (unsigned).
- a  input  16  multiplicand / dividend; sampled with start.
- b  input  16  multiplier / divisor; sampled with start.
- busy  output  1  high while iterating (CALC).
- done  output  1  one-cycle pulse; results valid.
- hi  output  16  MUL: product[31:16]; DIV: remainder.
- lo  output  16  MUL: product[15:0]; DIV: quotient.
- c  output  1  MUL: hi != 0 (16-bit overflow); DIV: 0.
- z  output  1  MUL: {hi,lo} == 0; DIV: lo == 0.
- n  output  1  MUL: hi[15]; DIV: lo[15].
- dz  output  1  divide by zero flag for the last DIV.

## Operation
- States: IDLE, CALC, DONE. Internal 5-bit iteration counter `cnt`.
- IDLE: if start=1, latch a, b and op, clear the accumulator, set cnt=0, and go to CALC. Exception: op=DIV with b=0 goes directly to DONE.
- CALC, MUL: if multiplier LSB=1, add the multiplicand to the upper accumulator (17-bit add keeps the carry). Shift the accumulator right by 1. cnt++.
- CALC, DIV: shift {rem,quo} left by 1. If rem >= b, subtract b and set quo[0]=1. cnt++.
- CALC exits to DONE on the edge where cnt==15, i.e. after 16 iterations.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- hi, lo, c, z, n and dz are registered. They update on the edge entering DONE and hold until the next operation enters DONE.
- Divide by zero: hi=a, lo=16'hFFFF, c=0, z=0, n=1, dz=1.
- Any completed operation other than divide by zero clears dz.
- start is ignored in CALC and DONE. It is not queued; the requester must wait for done and IDLE.
- a and b may change freely after the start cycle.

## Timing
- Reset: state=IDLE, cnt=0, and busy, done, hi, lo, c, z, n, dz all 0.
- Reset during CALC or DONE aborts the operation. No done pulse; outputs are zeroed.
- Reset wins over start in the same cycle.
- Normal latency: start high at edge E0. busy is high in cycles E0+1 through E0+16. done is high in cycle E0+17. IDLE resumes in cycle E0+18, which is the earliest next accepted start.
- Divide-by-zero latency: done is high in cycle E0+1 and busy never asserts.
- busy and done are never high together.
- Throughput: one operation per 18 cycles (2 for divide by zero).

## Test plan
- MUL a=3, b=5 → done at start+17; hi=0000, lo=000F, c=0, z=0, n=0; busy high for exactly 16 cycles.
- MUL a=FFFF, b=FFFF → hi=FFFE, lo=0001, c=1, n=1, z=0. Then MUL a=0, b=1234 → hi=0, lo=0, z=1, c=0.
- DIV a=100, b=7 → lo=000E, hi=0002, dz=0, z=0. DIV a=5, b=9 → lo=0, hi=5, z=1.
- DIV a=1234, b=0 → done at start+1; hi=1234, lo=FFFF, dz=1, n=1. A following valid DIV clears dz.
- Pulse start again with different operands at cycles +5 (CALC) and +17 (DONE) → both ignored; original result returned. A start at +18 is accepted.
- Assert rst at start+8 → next cycle busy=0, done=0, all result outputs 0. No done pulse follows. A fresh MUL 3×5 then completes correctly.
